// File: rtl/dm_pkg.sv
// Shared constants for the data memory: access size codes and FSM state encodings.
package dm_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } dm_state_e;

endpackage

// File: rtl/dm_lane_merge.sv
// Lane steering for sized accesses: merges store data into the old word and
// extracts/extends the addressed lane for loads.
module dm_lane_merge
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        load_unsigned,
  output logic [31:0] merged,
  output logic [31:0] load_val
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    merged   = old_word;
    load_val = old_word;
    half_sel = addr_lo[1] ? old_word[31:16] : old_word[15:0];
    byte_sel = old_word[{addr_lo, 3'b000} +: 8];
    case (size)
      SZ_WORD: merged = wdata;
      SZ_HALF: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
        load_val = load_unsigned ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SZ_BYTE: begin
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        load_val = load_unsigned ? {24'h00_0000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_sized_mem.sv
// Data memory for the MEM stage: sized loads/stores, registered 1-cycle response,
// fault detection and clear-on-reset. Optional store trace with DM_TRACE_EN.
//
// state    | meaning
// ST_CLEAR | zeroing mem one word per cycle; requests ignored
// ST_IDLE  | accepting one request per cycle
module dm_sized_mem
  import dm_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  dm_state_e   state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [31:0]   mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          fault;
  logic          accept;
  logic [31:0]   rd_word;
  logic [31:0]   merged;
  logic [31:0]   load_val;

  assign off    = req_addr - BASE_ADDR;
  assign idx    = off[AW+1:2];
  assign rd_word = mem[idx];
  assign accept = req_valid && (state_q == ST_IDLE);

  assign fault = (req_size == SZ_ILL)
              || ((req_size == SZ_HALF) && req_addr[0])
              || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
              || ({1'b0, off} >= SPAN);

  dm_lane_merge u_lane (
    .old_word      (rd_word),
    .wdata         (req_wdata),
    .size          (req_size),
    .addr_lo       (req_addr[1:0]),
    .load_unsigned (req_unsigned),
    .merged        (merged),
    .load_val      (load_val)
  );

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_rdata_d = '0;
    mem_we      = 1'b0;
    mem_waddr   = clr_idx_q;
    mem_wdata   = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
      end
      default: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          if (fault) begin
            rsp_fault_d = 1'b1;
          end else if (req_we) begin
            mem_we      = 1'b1;
            mem_waddr   = idx;
            mem_wdata   = merged;
            rsp_rdata_d = merged;
          end else begin
            rsp_rdata_d = load_val;
          end
        end
      end
    endcase
    // Reset wins over any clear step or request in the same cycle.
    if (reset) begin
      state_d     = ST_CLEAR;
      clr_idx_d   = '0;
      rsp_valid_d = 1'b0;
      rsp_fault_d = 1'b0;
      rsp_rdata_d = '0;
      mem_we      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    clr_idx_q   <= clr_idx_d;
    rsp_valid_q <= rsp_valid_d;
    rsp_fault_q <= rsp_fault_d;
    rsp_rdata_q <= rsp_rdata_d;
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && accept && req_we && !fault)
      $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CLEAR);
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dm_sized_mem.sv
// Bench for dm_sized_mem: directed access cases, clear timing and random
// traffic against an arithmetic reference memory.
module tb_dm_sized_mem;

  localparam int          DEPTH     = 256;
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  dm_sized_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_pc       (req_pc),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Reference behaviour from the access rules, using shifts and masks on whole words.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic flt, output logic [31:0] data);
    logic [31:0] off, w, mask, v;
    int sh;
    off  = addr - BASE_ADDR;
    flt  = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd0 && addr % 4 != 0) || (off >= SPAN);
    data = '0;
    if (flt) return;
    w  = ref_mem[off[AW+1:2]];
    sh = int'(addr % 4) * 8;
    if (we) begin
      case (size)
        2'd0:    w = wdata;
        2'd1:    begin mask = 32'hFFFF << sh; w = (w & ~mask) | ((wdata & 32'hFFFF) << sh); end
        default: begin mask = 32'hFF << sh;   w = (w & ~mask) | ((wdata & 32'hFF) << sh); end
      endcase
      ref_mem[off[AW+1:2]] = w;
      data = w;
    end else begin
      v = w >> sh;
      if (size == 2'd1) begin
        v = v & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end else if (size == 2'd2) begin
        v = v & 32'hFF;
        if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      data = v;
    end
  endtask

  // Drive one request at a falling edge and check its response one cycle later.
  task automatic issue(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] got);
    logic        eflt;
    logic [31:0] edata;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_pc       = $urandom;
    model(we, size, uns, addr, wdata, eflt, edata);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".fault"}, 32'(rsp_fault), 32'(eflt));
    check({tag, ".rdata"}, rsp_rdata, edata);
    got = rsp_rdata;
  endtask

  // Count busy cycles while hammering the DUT with requests that must be ignored.
  task automatic count_clear(output int n, output int stray);
    n = 0;
    stray = 0;
    while (busy && n < DEPTH + 20) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b00;
      req_addr  = 32'(n % DEPTH) * 4;
      req_wdata = 32'hDEAD_0000 | 32'(n);
      if (req_ready) stray++;
      n++;
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    req_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_clear();
  endtask

  initial begin
    logic [31:0] got;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    int          ncyc, stray;

    ref_clear();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd1);
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    ref_clear();
    count_clear(ncyc, stray);
    check("clear.cycles", 32'(ncyc), 32'(DEPTH));
    check("clear.ignored", 32'(stray), 32'd0);
    check("idle.ready", 32'(req_ready), 32'd1);

    issue("ld0", 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, got);
    check("ld0.zero", got, 32'h0);

    issue("sw10", 1'b1, 2'b00, 1'b0, 32'h10, 32'h1234_5678, got);
    @(negedge clk);
    check("pulse.idle", 32'(rsp_valid), 32'd0);
    issue("lbu13", 1'b0, 2'b10, 1'b1, 32'h13, 32'h0, got);
    check("lbu13.const", got, 32'h0000_0012);
    issue("lb10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    check("lb10.const", got, 32'h0000_0078);
    issue("sb11", 1'b1, 2'b10, 1'b0, 32'h11, 32'h0000_0080, got);
    check("sb11.const", got, 32'h1234_8078);
    issue("lh10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, got);
    check("lh10.const", got, 32'hFFFF_8078);
    issue("lhu10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, got);
    check("lhu10.const", got, 32'h0000_8078);

    issue("sh21", 1'b1, 2'b01, 1'b0, 32'h21, 32'hAAAA_BBBB, got);
    issue("lw20", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, got);
    check("sh21.nowrite", got, 32'h0);
    issue("lw22", 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, got);
    issue("ill", 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, got);
    issue("oor", 1'b1, 2'b00, 1'b0, BASE_ADDR + SPAN, 32'h5555_5555, got);
    issue("lw10.after", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, got);
    check("lw10.after.const", got, 32'h1234_8078);

    issue("bb.sw1", 1'b1, 2'b00, 1'b0, 32'h40, 32'hCAFE_0001, got);
    issue("bb.sw2", 1'b1, 2'b00, 1'b0, 32'h40, 32'hBEEF_0002, got);
    issue("bb.lw", 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, got);
    check("bb.lw.const", got, 32'hBEEF_0002);

    for (int i = 0; i < 400; i++) begin
      we   = 1'($urandom % 2);
      size = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      if ($urandom % 6 == 0) addr = $urandom_range(DEPTH * 4 - 8, DEPTH * 4 + 64);
      else                   addr = $urandom_range(0, 127);
      if ($urandom % 4 != 0) begin
        if (size == 2'b00) addr = addr & ~32'h3;
        if (size == 2'b01) addr = addr & ~32'h1;
      end
      issue($sformatf("rnd%0d", i), we, size, 1'($urandom % 2), addr, $urandom, got);
    end

    issue("mid.sw", 1'b1, 2'b00, 1'b0, 32'h44, 32'h7777_8888, got);
    pulse_reset();
    for (int i = 0; i < 99; i++) @(negedge clk);
    check("mid.busy", 32'(busy), 32'd1);
    pulse_reset();
    count_clear(ncyc, stray);
    check("mid.cycles", 32'(ncyc), 32'(DEPTH));
    check("mid.ignored", 32'(stray), 32'd0);
    issue("mid.lw44", 1'b0, 2'b00, 1'b0, 32'h44, 32'h0, got);
    check("mid.lw44.const", got, 32'h0);
    issue("mid.lw40", 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, got);
    check("mid.lw40.const", got, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
